// File: rtl/trit_counter_if.sv
// rtl/trit_counter_if.sv - control/result bundle between a trit counter and its driver
//
// Purpose: carries the counter's control inputs and its registered results.
// Signals:
//   clear    - synchronous clear of value and flags
//   load     - load load_val this cycle
//   load_val - trit-encoded value to load (2 bits per trit)
//   en, up   - step enable and direction (1 = increment)
//   q        - counter value, trit i at [2i+1:2i]
//   wrap     - one-cycle pulse when q shows a post-wrap value
//   done     - one-shot sequence complete
//   err      - sticky illegal-trit-on-load flag
// Modports: master drives controls and observes results, slave is the counter.

interface trit_counter_if #(
  parameter int NTRITS = 2
);
  logic                  clear;
  logic                  load;
  logic [2*NTRITS-1:0]   load_val;
  logic                  en;
  logic                  up;
  logic [2*NTRITS-1:0]   q;
  logic                  wrap;
  logic                  done;
  logic                  err;

  modport master (
    output clear, load, load_val, en, up,
    input  q, wrap, done, err
  );

  modport slave (
    input  clear, load, load_val, en, up,
    output q, wrap, done, err
  );
endinterface

// File: rtl/trit_counter.sv
// rtl/trit_counter.sv - synchronous N-trit up/down counter with 2-bit trit encoding
//
// Purpose: base-3 counter producing a ternary word (00=0, 01=1, 10=2) that
// sweeps all 3^NTRITS operand combinations for downstream ternary gates.
// Parameters:
//   NTRITS  - number of trits, q is 2*NTRITS bits wide
//   ONESHOT - 1: stop at done after one full wrap, 0: free-run
// Ports:
//   clk     - rising-edge clock
//   rst_n   - synchronous active-low reset
//   bus     - trit_counter_if slave (controls in, q/wrap/done/err out)

module trit_counter #(
  parameter int NTRITS  = 2,
  parameter bit ONESHOT = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  trit_counter_if.slave   bus
);
  localparam int W = 2 * NTRITS;

  logic [W-1:0] q_r;
  logic         wrap_r;
  logic         done_r;
  logic         err_r;

  logic [W-1:0] inc_q;
  logic [W-1:0] dec_q;
  logic [W-1:0] load_q;
  logic         inc_wrap;
  logic         dec_wrap;
  logic         load_ill;
  logic         halted;
  logic         step;

  // Increment: ripple a carry from trit 0; a trit at 2 rolls to 0 and passes
  // the carry on. A carry out of the top trit is the modulo wrap.
  always_comb begin : inc_chain
    logic       c;
    logic [1:0] t;
    c     = 1'b1;
    t     = 2'd0;
    inc_q = q_r;
    for (int i = 0; i < NTRITS; i++) begin
      t = q_r[2*i +: 2];
      if (c) begin
        if (t == 2'd2) begin
          inc_q[2*i +: 2] = 2'd0;
        end else begin
          inc_q[2*i +: 2] = t + 2'd1;
          c = 1'b0;
        end
      end
    end
    inc_wrap = c;
  end

  // Decrement: ripple a borrow; a trit at 0 rolls to 2 and passes it on.
  always_comb begin : dec_chain
    logic       b;
    logic [1:0] t;
    b     = 1'b1;
    t     = 2'd0;
    dec_q = q_r;
    for (int i = 0; i < NTRITS; i++) begin
      t = q_r[2*i +: 2];
      if (b) begin
        if (t == 2'd0) begin
          dec_q[2*i +: 2] = 2'd2;
        end else begin
          dec_q[2*i +: 2] = t - 2'd1;
          b = 1'b0;
        end
      end
    end
    dec_wrap = b;
  end

  // Loaded trits equal to 11 are forced to 00 so q never holds an illegal trit.
  always_comb begin : load_sanitize
    logic [1:0] t;
    t        = 2'd0;
    load_q   = '0;
    load_ill = 1'b0;
    for (int i = 0; i < NTRITS; i++) begin
      t = bus.load_val[2*i +: 2];
      if (t == 2'd3) begin
        load_ill = 1'b1;
      end else begin
        load_q[2*i +: 2] = t;
      end
    end
  end

  // In one-shot mode a finished sequence ignores en until clear/load/reset.
  assign halted = ONESHOT && done_r;
  assign step   = bus.en && !halted;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else if (bus.clear) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else if (bus.load) begin
      q_r    <= load_q;
      wrap_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= err_r | load_ill;
    end else if (step) begin
      if (bus.up) begin
        q_r    <= inc_q;
        wrap_r <= inc_wrap;
        if (ONESHOT && inc_wrap) done_r <= 1'b1;
      end else begin
        q_r    <= dec_q;
        wrap_r <= dec_wrap;
        if (ONESHOT && dec_wrap) done_r <= 1'b1;
      end
    end else begin
      wrap_r <= 1'b0;
    end
  end

  assign bus.q    = q_r;
  assign bus.wrap = wrap_r;
  assign bus.done = done_r;
  assign bus.err  = err_r;

endmodule

// File: tb/tb_trit_counter.sv
// tb/tb_trit_counter.sv - self-checking bench for trit_counter (free-run and one-shot)

module tb_trit_counter;
  localparam int NT = 2;
  localparam int M  = 9;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  trit_counter_if #(.NTRITS(NT)) bus0 ();
  trit_counter_if #(.NTRITS(NT)) bus1 ();

  trit_counter #(.NTRITS(NT), .ONESHOT(1'b0)) dut_free (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  trit_counter #(.NTRITS(NT), .ONESHOT(1'b1)) dut_once (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference state: counter as an integer 0..8, flags as bits
  int mv[2];
  bit merr[2], mdone[2], mwrap[2];

  logic c_clear, c_load, c_en, c_up;
  logic [3:0] c_lv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] enc(input int v);
    logic [1:0] lo, hi;
    lo = 2'(v % 3);
    hi = 2'((v / 3) % 3);
    return {hi, lo};
  endfunction

  task automatic drive(input logic cl, input logic ld, input logic [3:0] lv,
                       input logic e, input logic u);
    c_clear = cl; c_load = ld; c_lv = lv; c_en = e; c_up = u;
    bus0.clear = cl; bus0.load = ld; bus0.load_val = lv; bus0.en = e; bus0.up = u;
    bus1.clear = cl; bus1.load = ld; bus1.load_val = lv; bus1.en = e; bus1.up = u;
  endtask

  task automatic model(input int k, input bit oneshot);
    int d0, d1;
    bit ill;
    if (!rst_n || c_clear) begin
      mv[k] = 0; merr[k] = 0; mdone[k] = 0; mwrap[k] = 0;
    end else if (c_load) begin
      d0 = int'(c_lv) % 4;
      d1 = int'(c_lv) / 4;
      ill = (d0 == 3) || (d1 == 3);
      if (d0 == 3) d0 = 0;
      if (d1 == 3) d1 = 0;
      mv[k] = d1 * 3 + d0;
      merr[k] = merr[k] | ill;
      mdone[k] = 0; mwrap[k] = 0;
    end else if (c_en && !(oneshot && mdone[k])) begin
      if (c_up) begin
        mwrap[k] = (mv[k] == M - 1);
        mv[k] = (mv[k] + 1) % M;
      end else begin
        mwrap[k] = (mv[k] == 0);
        mv[k] = (mv[k] + M - 1) % M;
      end
      if (oneshot && mwrap[k]) mdone[k] = 1;
    end else begin
      mwrap[k] = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".q0"},    32'(bus0.q),    32'(enc(mv[0])));
    check({tag, ".wrap0"}, 32'(bus0.wrap), 32'(mwrap[0]));
    check({tag, ".done0"}, 32'(bus0.done), 32'd0);
    check({tag, ".err0"},  32'(bus0.err),  32'(merr[0]));
    check({tag, ".q1"},    32'(bus1.q),    32'(enc(mv[1])));
    check({tag, ".wrap1"}, 32'(bus1.wrap), 32'(mwrap[1]));
    check({tag, ".done1"}, 32'(bus1.done), 32'(mdone[1]));
    check({tag, ".err1"},  32'(bus1.err),  32'(merr[1]));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model(0, 1'b0);
    model(1, 1'b1);
    #1;
    compare_all(tag);
  endtask

  logic [3:0] sweep [10];

  initial begin
    sweep[0] = 4'b0000; sweep[1] = 4'b0001; sweep[2] = 4'b0010;
    sweep[3] = 4'b0100; sweep[4] = 4'b0101; sweep[5] = 4'b0110;
    sweep[6] = 4'b1000; sweep[7] = 4'b1001; sweep[8] = 4'b1010;
    sweep[9] = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      mv[k] = 0; merr[k] = 0; mdone[k] = 0; mwrap[k] = 0;
    end

    // reset held with en and load active
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 4'b0101, 1'b1, 1'b1);
    cycle("rst_a");
    cycle("rst_b");
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    cycle("rst_rel");
    check("rst_rel.q_const", 32'(bus0.q), 32'h0);

    // full up sweep: operands A=q[3:2], B=q[1:0]
    drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      cycle("sweep");
      check("sweep.q_tbl", 32'(bus0.q), 32'(sweep[i]));
      check("sweep.a_b", 32'({bus0.q[3:2], bus0.q[1:0]}), 32'({2'((i % 9) / 3), 2'((i % 9) % 3)}));
    end

    // one-shot stays done after the wrap
    for (int i = 0; i < 3; i++) cycle("oneshot_hold");
    check("oneshot_hold.q1", 32'(bus1.q), 32'h0);

    // down wrap from zero
    drive(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    cycle("dn_load");
    drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    cycle("dn_wrap");
    check("dn_wrap.q_const", 32'(bus0.q), 32'b1010);
    check("dn_wrap.w_const", 32'(bus0.wrap), 32'd1);
    cycle("dn_next");
    check("dn_next.q_const", 32'(bus0.q), 32'b1001);

    // illegal trit on load
    drive(1'b0, 1'b1, 4'b1101, 1'b0, 1'b1);
    cycle("ill_load");
    check("ill_load.q_const", 32'(bus0.q), 32'b0001);
    drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    cycle("ill_cnt");
    cycle("ill_cnt");
    drive(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
    cycle("ill_clear");

    // priority
    drive(1'b1, 1'b1, 4'b0110, 1'b1, 1'b1);
    cycle("pri_clr");
    drive(1'b0, 1'b1, 4'b0110, 1'b1, 1'b1);
    cycle("pri_load");
    check("pri_load.q_const", 32'(bus0.q), 32'b0110);

    // reset mid-count at q=1001
    drive(1'b0, 1'b1, 4'b1001, 1'b0, 1'b1);
    cycle("mid_load");
    drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    rst_n = 1'b0;
    cycle("mid_rst");
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
            4'($urandom), $urandom_range(0, 3) != 0, 1'($urandom));
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/trit_counter.md
Name: trit_counter

Overview:
- Synchronous N-trit up/down counter that produces a ternary word in 2-bit-per-trit encoding: 00=0, 01=1, 10=2; 11 is illegal.
- Sits directly upstream of the ternary NOR gate. With NTRITS=2, q[3:2] drives the gate's A operand and q[1:0] drives its B operand.
- One full cycle therefore sweeps all 9 operand pairs, in the order 00/00, 00/01, 00/10, 01/00 … 10/10.
- Also usable as a general trit-register source for other ternary gates.

Parameters:
- NTRITS, 2, number of trits; q width is 2*NTRITS.
- ONESHOT, 0, 1 = halt at done after one full wrap; 0 = free-run.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- clear  in  1  synchronous clear to zero; also clears err and done.
- load  in  1  load load_val.
- load_val  in  2*NTRITS  value to load, trit-encoded.
- en  in  1  count step enable.
- up  in  1  1 = increment, 0 = decrement.
- q  out  2*NTRITS  registered counter value; trit i occupies bits [2i+1:2i].
- wrap  out  1  one-cycle pulse on modulo wrap.
- done  out  1  ONESHOT only: sequence complete; held high.
- err  out  1  sticky flag: an illegal trit (11) was seen on load_val.

Behaviour:
- All state updates on the rising edge of clk. One clock; reset is synchronous and active-low (rst_n sampled on clk).
- Reset (rst_n=0): q=0, wrap=0, done=0, err=0. Reset overrides every other input, including mid-count.
- Per-cycle priority: rst_n > clear > load > en. Lower-priority inputs are ignored in a cycle where a higher one is active.
- clear=1: q=0, done=0, err=0, wrap=0.
- load=1:
  - q <= load_val, except that any trit equal to 11 is replaced by 00.
  - err <= 1 if any trit was 11; otherwise err keeps its value.
  - done <= 0; wrap=0.
- en=1, up=1: base-3 increment starting from trit 0.
  - A trit at 2 becomes 0 and carries into the next trit; a trit at 0 or 1 increments and stops the carry.
- en=1, up=0: base-3 decrement.
  - A trit at 0 becomes 2 and borrows from the next trit; a trit at 1 or 2 decrements and stops the borrow.
- Modulo 3^NTRITS: all-2 + 1 -> all-0, and all-0 − 1 -> all-2.
- wrap:
  - Registered; high for exactly the one cycle in which q shows the post-wrap value (same edge as the q update).
  - Low in every other cycle, including load and clear cycles.
- en=0 and no clear/load: q holds and wrap=0.
- ONESHOT=1:
  - On the edge that wraps, done <= 1 and q shows the wrapped value.
  - While done=1, en is ignored and q holds.
  - Only clear, load or reset leave the done state.
- ONESHOT=0: done is tied 0.
- Invariant: q never contains a trit equal to 11 in any cycle.
- Latency: q reflects any action 1 cycle after the sampling edge. No combinational path from inputs to outputs.
- Size: counter state machine per trit plus carry/borrow chain; roughly 150–250 lines of RTL.

Test Plan:
- Reset: rst_n=0 for 2 cycles with en=1 and load=1 -> q=0000, wrap=0, done=0, err=0 throughout; after release, q=0000.
- Up sweep (NTRITS=2, ONESHOT=0): en=1, up=1 for 9 cycles -> q = 0000, 0001, 0010, 0100, 0101, 0110, 1000, 1001, 1010, then 0000.
  - wrap is high only in the cycle where q returns to 0000.
  - The gate operands A/B match the 9-pair order 00/00 … 10/10.
- Down wrap: load 0000, then en=1, up=0 -> q=1010 with wrap=1 for one cycle; next step -> 1001 with wrap=0.
- Illegal load: load_val=1101 -> q=0001, err=1; err stays 1 after further counting; clear -> q=0000, err=0.
- Priority: clear=1, load=1, en=1 in the same cycle -> q=0000. Then load=1, en=1 with load_val=0110 -> q=0110, not incremented.
- One-shot (ONESHOT=1): 9 up steps -> done=1 and q=0000. Further en=1 cycles keep q=0000 with wrap=0; load 0001 -> done=0 and counting resumes.
- Reset mid-count: assert rst_n=0 at q=1001 with en=1 -> next q=0000, wrap=0.
